// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and sequencer sharing one I2C master engine among NUM_REQ
// requesters. Launches one-byte transfers and returns read data and an error flag.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned IDX_W         = 2,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned XFER_TIMEOUT  = 32'd2_000_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ-1:0]   i_req_rw,
  input  logic [3*NUM_REQ-1:0] i_req_adr,
  input  logic [8*NUM_REQ-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_resp_valid,
  output logic [7:0]           o_resp_rdata,
  output logic                 o_resp_err,
  output logic                 o_timeout_flag,
  output logic                 o_m_en,
  output logic                 o_m_rw,
  output logic [2:0]           o_m_adr,
  output logic [7:0]           o_m_wdata,
  input  logic                 i_m_busy,
  input  logic                 i_m_nack,
  input  logic [7:0]           i_m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE
  } state_t;

  localparam logic [31:0]      START_LAST = 32'(START_TIMEOUT - 1);
  localparam logic [31:0]      XFER_LAST  = 32'(XFER_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_rr_ptr, r_win, w_win_idx;
  logic [NUM_REQ-1:0] w_rot, w_win_oh;
  logic               w_found, w_sel_rw;
  logic [2:0]         w_sel_adr;
  logic [7:0]         w_sel_wdata;
  logic [31:0]        r_cnt;
  logic               w_start_to, w_xfer_to, w_done;

  // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
  always_comb begin
    w_rot       = NUM_REQ'({i_req_valid, i_req_valid} >> r_rr_ptr);
    w_found     = 1'b0;
    w_win_idx   = '0;
    w_win_oh    = '0;
    w_sel_rw    = 1'b0;
    w_sel_adr   = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!w_found && w_rot[k]) begin
        w_found   = 1'b1;
        w_win_idx = (int'(r_rr_ptr) + k >= int'(NUM_REQ)) ?
                    IDX_W'(int'(r_rr_ptr) + k - int'(NUM_REQ)) :
                    IDX_W'(int'(r_rr_ptr) + k);
      end
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_win_idx == IDX_W'(k)) begin
        w_win_oh[k] = 1'b1;
        w_sel_rw    = i_req_rw[k];
        w_sel_adr   = i_req_adr[3*k +: 3];
        w_sel_wdata = i_req_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_to   = 1'b0;
    w_xfer_to    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:      if (w_found && !i_m_busy) w_state_next = S_LAUNCH;
      S_LAUNCH:    w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_m_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (r_cnt == START_LAST) begin
          w_start_to   = 1'b1;
          w_state_next = S_COMPLETE;
        end
      end
      S_WAIT_DONE: begin
        if (!i_m_busy) begin
          w_done       = 1'b1;
          w_state_next = S_COMPLETE;
        end else if (r_cnt == XFER_LAST) begin
          w_xfer_to    = 1'b1;
          w_state_next = S_COMPLETE;
        end
      end
      S_COMPLETE:  w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_LAUNCH || (r_state == S_WAIT_BUSY && i_m_busy)) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) && r_cnt != '1) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Response fields are loaded on entry to COMPLETE, so they are valid only with resp_valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr       <= '0;
      r_win          <= '0;
      o_gnt          <= '0;
      o_resp_valid   <= '0;
      o_resp_rdata   <= '0;
      o_resp_err     <= 1'b0;
      o_timeout_flag <= 1'b0;
      o_m_en         <= 1'b0;
      o_m_rw         <= 1'b0;
      o_m_adr        <= '0;
      o_m_wdata      <= '0;
    end else begin
      o_m_en       <= 1'b0;
      o_resp_valid <= '0;
      o_resp_rdata <= '0;
      o_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_state_next == S_LAUNCH) begin
            r_win     <= w_win_idx;
            o_gnt     <= w_win_oh;
            o_m_en    <= 1'b1;
            o_m_rw    <= w_sel_rw;
            o_m_adr   <= w_sel_adr;
            o_m_wdata <= w_sel_wdata;
          end
        end
        S_WAIT_BUSY: begin
          if (w_start_to) begin
            o_resp_valid   <= o_gnt;
            o_resp_err     <= 1'b1;
            o_timeout_flag <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (w_done) begin
            o_resp_valid <= o_gnt;
            o_resp_err   <= i_m_nack;
            o_resp_rdata <= (o_m_rw && !i_m_nack) ? i_m_rdata : 8'h00;
          end else if (w_xfer_to) begin
            o_resp_valid   <= o_gnt;
            o_resp_err     <= 1'b1;
            o_timeout_flag <= 1'b1;
          end
        end
        S_COMPLETE: begin
          o_gnt    <= '0;
          r_rr_ptr <= (r_win == LAST_IDX) ? '0 : r_win + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized scoreboard bench for i2c_master_arbiter: a reference arbiter/engine
// model predicts each launch and response; a monitor pops and compares them.
module tb_i2c_master_arbiter;
  localparam int N = 4;
  localparam int M_OK = 0, M_NACK = 1, M_RAND = 2, M_NEVER = 3, M_STUCK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_rw;
  logic [11:0] req_adr;
  logic [31:0] req_wdata;
  logic [3:0]  o_gnt, o_resp_valid;
  logic [7:0]  o_resp_rdata, o_m_wdata, m_rdata;
  logic        o_resp_err, o_timeout_flag, o_m_en, o_m_rw;
  logic [2:0]  o_m_adr;
  logic        m_busy, m_nack;

  i2c_master_arbiter #(.NUM_REQ(4), .IDX_W(2), .START_TIMEOUT(4), .XFER_TIMEOUT(50)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_rw(req_rw),
    .i_req_adr(req_adr), .i_req_wdata(req_wdata), .o_gnt(o_gnt),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_timeout_flag(o_timeout_flag), .o_m_en(o_m_en), .o_m_rw(o_m_rw),
    .o_m_adr(o_m_adr), .o_m_wdata(o_m_wdata), .i_m_busy(m_busy),
    .i_m_nack(m_nack), .i_m_rdata(m_rdata));

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    int         at;
    logic       err;
    logic [7:0] rdata;
    logic       tflag;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_log[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, n_launch = 0, mdl_ptr = 0;
  logic tf_mdl = 1'b0;
  int   cfg_mode = M_OK, cfg_len_fix = 0;
  logic cfg_rd_fix_en = 1'b0;
  logic [7:0] cfg_rd = 8'h00;
  int   repost_cnt [N];
  logic eng_req = 1'b0;
  int   eng_mode, eng_d, eng_len;
  logic eng_nack;
  logic [7:0] eng_rdata;
  logic chk_after = 1'b0;

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic post(input int i, input logic rw, input logic [2:0] adr, input logic [7:0] wd);
    req_valid[i]      = 1'b1;
    req_rw[i]         = rw;
    req_adr[3*i +: 3] = adr;
    req_wdata[8*i +: 8] = wd;
    $display("post   req=%0d rw=%0d adr=%0d wdata=%02h (cycle %0d)", i, rw, adr, wd, cyc);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(req_valid == 0 && exp_q.size() == 0 && !m_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 64'(n >= budget), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_launch(input int budget, input string tag);
    int start = n_launch;
    int n = 0;
    while (n_launch == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_launch"}, 64'(n_launch == start), 64'(0));
  endtask

  // Engine model: raises busy d cycles after m_en, holds it len cycles, then reports status.
  initial begin : engine
    m_busy = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    forever begin
      wait (eng_req);
      eng_req = 1'b0;
      if (eng_mode != M_NEVER) begin
        repeat (eng_d) @(posedge clk);
        @(negedge clk);
        m_busy = 1'b1; m_nack = 1'b0; m_rdata = 8'h00;
        repeat (eng_len) @(posedge clk);
        @(negedge clk);
        m_busy = 1'b0; m_nack = eng_nack; m_rdata = eng_rdata;
      end
    end
  end

  initial begin : monitor
    logic busy_s, rst_s;
    int   win, j, b;
    exp_t e;
    forever begin
      @(posedge clk);
      busy_s = m_busy;
      rst_s  = rst;
      cyc++;
      #1;
      if (rst_s) continue;
      if (chk_after) begin
        chk("post_resp_idle", {o_gnt, o_m_en}, 5'b0);
        chk_after = 1'b0;
      end
      if (o_m_en) begin
        n_launch++;
        chk("launch_clean", {(exp_q.size() != 0), busy_s}, 2'b00);
        win = -1;
        for (int k = 0; k < N; k++) begin
          j = (mdl_ptr + k) % N;
          if (win < 0 && req_valid[j]) win = j;
        end
        if (win < 0) begin
          checks++; errors++;
          $display("FAIL launch_spurious: got m_en with no request, expected none (cycle %0d)", cyc);
        end else begin
          gnt_log.push_back(win);
          chk("launch_cmd", {o_gnt, o_m_rw, o_m_adr, o_m_wdata},
              {onehot(win), req_rw[win], req_adr[3*win +: 3], req_wdata[8*win +: 8]});
          eng_mode  = cfg_mode;
          eng_d     = $urandom_range(0, 2);
          eng_len   = (cfg_len_fix != 0) ? cfg_len_fix : $urandom_range(2, 40);
          eng_rdata = cfg_rd_fix_en ? cfg_rd : 8'($urandom);
          eng_nack  = (cfg_mode == M_NACK) || (cfg_mode == M_RAND && $urandom_range(0, 3) == 0);
          e.idx = win;
          if (cfg_mode == M_NEVER || cfg_mode == M_STUCK) begin
            tf_mdl  = 1'b1;
            e.err   = 1'b1;
            e.rdata = 8'h00;
            if (cfg_mode == M_NEVER) begin
              e.at = cyc + 5;
            end else begin
              eng_len = 80;
              b = (cyc + 1 + eng_d > cyc + 2) ? cyc + 1 + eng_d : cyc + 2;
              e.at = b + 50;
            end
          end else begin
            e.err   = eng_nack;
            e.rdata = (req_rw[win] && !eng_nack) ? eng_rdata : 8'h00;
            e.at    = cyc + 1 + eng_d + eng_len;
          end
          e.tflag = tf_mdl;
          exp_q.push_back(e);
          eng_req = 1'b1;
          $display("launch req=%0d rw=%0d adr=%0d wdata=%02h mode=%0d (cycle %0d)",
                   win, req_rw[win], req_adr[3*win +: 3], req_wdata[8*win +: 8], cfg_mode, cyc);
        end
      end
      if (o_resp_valid != 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: got resp_valid=%b, expected none (cycle %0d)", o_resp_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("resp", {o_resp_valid, o_resp_err, o_resp_rdata, o_timeout_flag},
              {onehot(e.idx), e.err, e.rdata, e.tflag});
          chk("resp_time", 64'(cyc), 64'(e.at));
          chk("resp_gnt", o_gnt, onehot(e.idx));
          $display("resp   req=%0d err=%0d rdata=%02h tflag=%0d (cycle %0d)",
                   e.idx, o_resp_err, o_resp_rdata, o_timeout_flag, cyc);
          mdl_ptr   = (e.idx + 1) % N;
          chk_after = 1'b1;
          if (repost_cnt[e.idx] > 0) begin
            repost_cnt[e.idx]--;
            post(e.idx, 1'($urandom), 3'($urandom), 8'($urandom));
          end else begin
            req_valid[e.idx] = 1'b0;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
        checks++; errors++;
        $display("FAIL resp_missing: got no resp_valid, expected one for req %0d at cycle %0d", exp_q[0].idx, exp_q[0].at);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int i;
    rst = 1'b1;
    req_valid = '0; req_rw = '0; req_adr = '0; req_wdata = '0;
    for (int k = 0; k < N; k++) repost_cnt[k] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_gnt", o_gnt, 4'b0);
    chk("reset_resp_valid", o_resp_valid, 4'b0);
    chk("reset_resp", {o_resp_rdata, o_resp_err}, 9'b0);
    chk("reset_tflag", o_timeout_flag, 1'b0);
    chk("reset_m_en", o_m_en, 1'b0);
    chk("reset_m_cmd", {o_m_rw, o_m_adr, o_m_wdata}, 12'b0);

    // Round-robin: all four requesting out of reset, each re-requesting once.
    @(negedge clk);
    cfg_mode = M_OK;
    for (int k = 0; k < N; k++) begin
      post(k, 1'($urandom), 3'($urandom), 8'($urandom));
      repost_cnt[k] = 1;
    end
    rst = 1'b0;
    wait_idle(3000, "rr");
    chk("rr_count", 64'(gnt_log.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("rr_order", 64'(gnt_log[k]), 64'(rr_exp[k]));

    @(negedge clk); post(1, 1'b0, 3'd5, 8'hA5);
    wait_idle(200, "write");

    cfg_rd_fix_en = 1'b1; cfg_rd = 8'h3C;
    @(negedge clk); post(2, 1'b1, 3'd3, 8'($urandom));
    wait_idle(200, "read");
    cfg_rd_fix_en = 1'b0;

    cfg_mode = M_NACK;
    @(negedge clk); post(0, 1'b1, 3'd6, 8'h11);
    wait_idle(200, "nack");

    cfg_mode = M_RAND;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      @(negedge clk);
      i = $urandom_range(0, N - 1);
      if (!req_valid[i]) post(i, 1'($urandom), 3'($urandom), 8'($urandom));
    end
    wait_idle(3000, "random");

    cfg_mode = M_NEVER;
    @(negedge clk); post(3, 1'b1, 3'd1, 8'h00);
    wait_idle(200, "never_busy");

    cfg_mode = M_STUCK;
    @(negedge clk); post(1, 1'b0, 3'd2, 8'h5A);
    wait_launch(50, "stuck");
    cfg_mode = M_OK;
    @(negedge clk); post(2, 1'b1, 3'd4, 8'h00);
    wait_idle(400, "stuck");

    @(negedge clk); post(0, 1'b0, 3'd7, 8'hC3);
    wait_idle(200, "pre_reset");

    // Reset while the engine is mid-transfer; the pending grant must be dropped.
    cfg_len_fix = 40;
    @(negedge clk); post(3, 1'b1, 3'd0, 8'h00);
    wait_launch(50, "abort");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_out", {o_gnt, o_resp_valid, o_resp_rdata, o_resp_err, o_timeout_flag,
                       o_m_en, o_m_rw, o_m_adr, o_m_wdata}, 64'(0));
    exp_q.delete();
    mdl_ptr = 0; tf_mdl = 1'b0; chk_after = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    cfg_len_fix = 0;
    wait_idle(200, "post_reset");
    @(negedge clk);
    post(2, 1'b0, 3'd1, 8'h22);
    post(0, 1'b0, 3'd2, 8'h44);
    wait_launch(20, "post_reset");
    chk("post_reset_winner", 64'(gnt_log[$]), 64'(0));
    wait_idle(300, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected completion within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C `Master` engine between `NUM_REQ` requesters. It accepts one-byte read/write requests, grants the engine to one requester at a time and launches the transaction with a single-cycle enable. It then tracks the engine's busy/done/nack status and returns read data plus an error flag to the winning requester. It sits between the on-chip clients and the I2C master in the top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_W`, 2: index width, ≥ clog2(`NUM_REQ`).
- `START_TIMEOUT`, 16: cycles to wait for `m_busy` to assert after `m_en`.
- `XFER_TIMEOUT`, 32'd2_000_000_000: cycles to wait for `m_busy` to deassert once the transfer has started.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request, level, held until its `resp_valid`.
- `req_rw` in `NUM_REQ`: 1 = read, 0 = write.
- `req_adr` in 3·`NUM_REQ`: slave memory address, requester i at [3i+2:3i].
- `req_wdata` in 8·`NUM_REQ`: write byte, requester i at [8i+7:8i].
- `gnt` out `NUM_REQ`: one-hot grant, held for the whole transaction.
- `resp_valid` out `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `resp_rdata` out 8: read byte, valid with `resp_valid`. Written as 0 on writes and errors.
- `resp_err` out 1: valid with `resp_valid`. 1 = NACK or timeout.
- `timeout_flag` out 1: sticky, set on any timeout, cleared only by `rst`.
- `m_en`, `m_rw`, `m_adr[2:0]`, `m_wdata[7:0]` out: engine command.
- `m_busy`, `m_nack`, `m_rdata[7:0]` in: engine status. `m_nack` is valid when `m_busy` falls.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
- **IDLE**
  - If any `req_valid` is high and `m_busy` is 0, pick the winner: the first set bit scanning upward from `rr_ptr` and wrapping at `NUM_REQ`-1 to 0.
  - Register the winner's index, `rw`, `adr` and `wdata`; go to LAUNCH.
  - If `m_busy` is 1 (engine still running after a timeout), stay in IDLE.
- **LAUNCH**
  - `m_en`=1 for exactly this cycle.
  - `gnt[winner]`=1, held until COMPLETE ends.
  - `m_rw`, `m_adr` and `m_wdata` come from registers and are stable from LAUNCH through COMPLETE.
  - Clear the timeout counter; go to WAIT_BUSY.
- **WAIT_BUSY**
  - `m_busy`=1 → clear counter, go to WAIT_DONE.
  - Counter reaches `START_TIMEOUT`-1 → error, go to COMPLETE.
- **WAIT_DONE**
  - `m_busy`=0 → capture `m_nack`; capture `m_rdata` if read; go to COMPLETE.
  - Counter reaches `XFER_TIMEOUT`-1 → error, go to COMPLETE.
- **COMPLETE**
  - `resp_valid[winner]`=1.
  - `resp_err` = captured NACK, or 1 on timeout.
  - `resp_rdata` = captured byte on a successful read, else 0.
  - `rr_ptr` ← winner+1, wrapping to 0 after `NUM_REQ`-1.
  - Go to IDLE; `gnt` clears on that transition.
- Timeout counter: 32-bit, saturating, counts only in WAIT_BUSY and WAIT_DONE.
- A granted requester dropping `req_valid` mid-transaction is ignored; the transaction still completes and still pulses `resp_valid`.
- A requester that keeps `req_valid` high after `resp_valid` is treated as a new request at lowest priority.
- No abort path: after a timeout the engine is never re-enabled while `m_busy`=1.
- `req_*` inputs of non-granted requesters are don't-care for the engine.

## Timing
- Reset: `state`=IDLE, `rr_ptr`=0, and every output is 0: `gnt`, `resp_valid`, `resp_rdata`, `resp_err`, `timeout_flag`, `m_en`, `m_rw`, `m_adr`, `m_wdata`.
- Reset mid-transaction: all outputs are 0 at the next edge and no `resp_valid` is issued.
- Request latency: a request sampled in IDLE at cycle T gives `gnt` and `m_en` high at T+1.
- Completion latency: `m_busy` sampled 0 in WAIT_DONE at cycle C gives `resp_valid` at C+1, `gnt`=0 at C+2, earliest next `m_en` at C+3.
- Outputs are registered; `m_en` has no combinational path from `req_valid`.
- A request arriving in the same cycle as COMPLETE is arbitrated in the following IDLE cycle with the updated `rr_ptr`.

## Test plan
- Single write: `req_valid[1]`, rw=0, adr=5, wdata=0xA5; engine model busy for 100 cycles, nack=0. Expect:
  - `gnt`=0010 and one `m_en` pulse with `m_adr`=5, `m_wdata`=0xA5.
  - `resp_valid[1]`, `resp_err`=0, `resp_rdata`=0.
- Read: requester 2, rw=1, adr=3; model returns 0x3C. Expect `resp_rdata`=0x3C and `resp_err`=0.
- Round-robin: all four `req_valid` held high from reset. Expect grant order 0,1,2,3,0 and exactly one `m_en` per transaction.
- NACK: model asserts `m_nack` at busy fall. Expect `resp_err`=1 and `timeout_flag`=0.
- Timeouts (`START_TIMEOUT`=4, `XFER_TIMEOUT`=50):
  - Model never busy → `resp_err`=1 four cycles after WAIT_BUSY entry, `timeout_flag`=1.
  - Model stuck busy → error after 50 cycles, no further `m_en` until `m_busy`=0.
- `rst` asserted during WAIT_DONE. Expect all outputs 0 next cycle, no `resp_valid`, and the next grant goes to requester 0.
